uart_rx_bins: RTL
=================

UART_RX_BINS -- requirements
Module: uart_rx_bins

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50_000_000, meaning clockIN frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate in bit/s.
REQ-003 SHALL have parameter PARITY, default 2'b01, meaning 2'b00 OFF, 2'b01 ODD, 2'b10 EVEN; 2'b11 is treated as OFF.
REQ-004 SHALL have port clockIN, input, 1 bit, the single clock.
REQ-005 SHALL have port nRxResetIN, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port rxIN, input, 1 bit, asynchronous serial line that idles high.
REQ-007 SHALL have port rxDataOUT, output, 8 bits, last received byte.
REQ-008 SHALL have port rxValidOUT, output, 1 bit, one-cycle pulse marking a completed frame.
REQ-009 SHALL have port rxParityErrOUT, output, 1 bit, parity mismatch flag for the byte on rxDataOUT.
REQ-010 SHALL have port rxFrameErrOUT, output, 1 bit, stop-bit error flag for the byte on rxDataOUT.
REQ-011 SHALL have port rxIdleOUT, output, 1 bit, high only in IDLE.

Function
REQ-012 SHALL pass rxIN through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rxS.
REQ-013 SHALL use BIT_CLKS = CLOCK_FREQUENCY/BAUD_RATE, HALF_CLKS = BIT_CLKS/2, and a bit-timing counter of $clog2(BIT_CLKS) bits.
REQ-014 SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE: on rxS 1->0, load counter with HALF_CLKS-1 and go to START.
REQ-016 START: at counter 0, if rxS=0 reload BIT_CLKS-1 and go to DATA; if rxS=1, treat it as a glitch and return to IDLE with no output activity.
REQ-017 DATA: at each counter 0, sample rxS into the shift register LSB first, and reload BIT_CLKS-1; after 8 samples go to PARITY (PARITY = 01/10) or STOP (otherwise).
REQ-018 PARITY: at counter 0, sample the parity bit; ODD requires XOR(data, pbit)=1, EVEN requires XOR(data, pbit)=0; a mismatch latches a pending parity error; then reload and go to STOP.
REQ-019 STOP: at counter 0, sample the stop bit; on the following clock rxDataOUT is updated, rxParityErrOUT and rxFrameErrOUT are updated (frame error = stop sample 0), and rxValidOUT pulses high for exactly 1 cycle.
REQ-020 After STOP, the block SHALL go to IDLE if the stop sample is 1, else to BREAK.
REQ-021 BREAK SHALL stay until rxS=1, then go to IDLE; a line held low SHALL produce no further rxValidOUT pulses.
REQ-022 rxDataOUT and both error flags SHALL hold their values until the next rxValidOUT; they are not cleared on read.
REQ-023 A falling edge on rxS outside IDLE SHALL NOT restart the frame.
REQ-024 A new frame SHALL be accepted from the first cycle in IDLE, so back-to-back frames with a single stop bit are received without loss.
REQ-025 Latency: rxValidOUT SHALL occur 1 cycle after the stop-bit mid-sample, which is about 2 + HALF_CLKS + (9 or 10)*BIT_CLKS cycles after the rxIN falling edge.

Reset
REQ-026 While nRxResetIN=0: state IDLE, counters 0, shift register 0, synchronizer 1, rxDataOUT 8'h00, rxValidOUT 0, rxParityErrOUT 0, rxFrameErrOUT 0, rxIdleOUT 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no rxValidOUT pulse; after release the block waits in IDLE for a fresh falling edge.

Verification (50 MHz, 115200 baud: BIT_CLKS=434, HALF_CLKS=217)
REQ-028 PARITY=01, send 0xA5 with parity bit 1 and stop 1 -> one rxValidOUT pulse, rxDataOUT=0xA5, both error flags 0.
REQ-029 PARITY=10, send 0x0F with parity bit 1 -> rxDataOUT=0x0F, rxParityErrOUT=1, rxFrameErrOUT=0.
REQ-030 PARITY=00, send 0x3C with stop bit 0, then hold rxIN low for 20 bit times, then release -> exactly one pulse with rxDataOUT=0x3C and rxFrameErrOUT=1, state BREAK until release, then IDLE.
REQ-031 A 100-cycle low glitch on idle rxIN -> no rxValidOUT, and rxIdleOUT returns to 1 within HALF_CLKS+3 cycles.
REQ-032 Two back-to-back frames, 0x55 then 0xAA, with no idle gap -> two pulses with correct data and no errors.
REQ-033 nRxResetIN pulsed low during data bit 4 of 0xFF -> no pulse, outputs at reset values, and the next frame 0x12 is received correctly.
REQ-034 Loopback from uart_tx_bins (same parameters) for 256 random bytes -> every byte matches.

Source files
------------

// File: rtl/uart_rx_bins.sv
// UART receiver: 8 data bits, LSB first, optional odd/even parity, one stop bit.
// Each bit is sampled at mid-bit; a low stop bit parks the receiver in BREAK until the line returns high.
module uart_rx_bins #(
    parameter int         CLOCK_FREQUENCY = 50_000_000,
    parameter int         BAUD_RATE       = 115200,
    parameter logic [1:0] PARITY          = 2'b01
) (
    input  logic       clockIN,
    input  logic       nRxResetIN,
    input  logic       rxIN,
    output logic [7:0] rxDataOUT,
    output logic       rxValidOUT,
    output logic       rxParityErrOUT,
    output logic       rxFrameErrOUT,
    output logic       rxIdleOUT
);

    localparam int BIT_CLKS  = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CW        = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;

    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CLKS - 1);
    localparam bit            PAR_EN    = (PARITY == 2'b01) || (PARITY == 2'b10);
    localparam bit            PAR_ODD   = (PARITY == 2'b01);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_err_q, par_err_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;

    logic        rx_meta_q, rx_s_q, rx_prev_q;

    // rx_prev_q trails the synchronized line by one cycle for falling-edge detection.
    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxIN;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s_q) begin
                    cnt_d     = BIT_LOAD;
                    bit_cnt_d = 3'd0;
                    par_err_d = 1'b0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Odd wants a total XOR of 1, even wants 0.
                    if ((^shift_q ^ rx_s_q) != PAR_ODD) begin
                        par_err_d = 1'b1;
                    end
                    cnt_d   = BIT_LOAD;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d  = shift_q;
                    perr_d  = par_err_q;
                    ferr_d  = !rx_s_q;
                    valid_d = 1'b1;
                    state_d = rx_s_q ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rxDataOUT      = data_q;
    assign rxValidOUT     = valid_q;
    assign rxParityErrOUT = perr_q;
    assign rxFrameErrOUT  = ferr_q;
    assign rxIdleOUT      = (state_q == ST_IDLE);

endmodule
